// File: rtl/alu_cmd_pkg.sv
// Shared types and default widths for the ALU command master.
package alu_cmd_pkg;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned OP_W_DEF    = 3;
   localparam int unsigned RES_W_DEF   = 16;
   localparam int unsigned QDEPTH_DEF  = 4;
   localparam int unsigned TIMEOUT_DEF = 255;

   // Controller states, kept as plain constants for legacy tooling
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t WAIT  = 2'd2;
   localparam state_t RESP  = 2'd3;

   // One buffered command at the default widths
   typedef struct packed {
      logic [DATA_W_DEF-1:0] a;
      logic [DATA_W_DEF-1:0] b;
      logic [OP_W_DEF-1:0]   op;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of command entries. Depth must be a power of two so the
// pointers wrap by plain overflow; count carries one extra bit to tell full.
module alu_cmd_fifo
   import alu_cmd_pkg::*;
#(
   parameter type         entry_t = cmd_t,
   parameter int unsigned DEPTH   = QDEPTH_DEF,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  entry_t         wdata,
   input  logic           pop,
   output entry_t         rdata,
   output logic           full,
   output logic           empty,
   output logic [PTR_W:0] count
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_master.sv
// Initiator for the ALU start/done handshake: buffers commands, issues them
// one at a time, waits for done (or times out) and returns the result.
// Optional statistics counters are enabled by defining ALU_CMD_MASTER_STATS_EN.
module alu_cmd_master
   import alu_cmd_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned OP_W    = OP_W_DEF,
   parameter int unsigned RES_W   = RES_W_DEF,
   parameter int unsigned QDEPTH  = QDEPTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] alu_A,
   output logic [DATA_W-1:0] alu_B,
   output logic [OP_W-1:0]   alu_op,
   output logic              alu_start,
   input  logic [RES_W-1:0]  alu_result,
   input  logic              alu_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_result,
   output logic              rsp_err,
   output logic              busy
`ifdef ALU_CMD_MASTER_STATS_EN
   ,
   output logic [15:0]       stat_done_cnt,
   output logic [15:0]       stat_timeout_cnt,
   output logic [7:0]        stat_spurious_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
   } entry_t;

   state_t         state_q, state_d;
   entry_t         cmd_q;
   entry_t         fifo_wdata;
   entry_t         fifo_rdata;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [PTR_W:0] fifo_count;
   logic [CNT_W-1:0] wait_cnt_q;
   logic           done_seen;
   logic           timed_out;

   assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: cmd_op};
   assign fifo_push  = cmd_valid && cmd_ready;

   alu_cmd_fifo #(
      .entry_t (entry_t),
      .DEPTH   (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // done is only meaningful while waiting; done beats a coincident timeout
   assign done_seen = (state_q == WAIT) && alu_done;

   // Next-state logic and the pop/timeout decisions
   always_comb begin
      state_d   = state_q;
      fifo_pop  = 1'b0;
      timed_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (alu_done) begin
               state_d = RESP;
            end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // TIMEOUT-th wait cycle without done
               timed_out = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, held operands, wait counter and the response register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         wait_cnt_q <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (fifo_pop) cmd_q <= fifo_rdata;
         if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
         if (done_seen) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
         end else if (timed_out) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
         end
      end
   end

   assign alu_A     = cmd_q.a;
   assign alu_B     = cmd_q.b;
   assign alu_op    = cmd_q.op;
   assign alu_start = (state_q == ISSUE);
   assign rsp_valid = (state_q == RESP);
   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != IDLE) || (fifo_count != '0);

`ifdef ALU_CMD_MASTER_STATS_EN
   logic spurious;
   assign spurious = alu_done && (state_q != WAIT);

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_done_cnt     <= '0;
         stat_timeout_cnt  <= '0;
         stat_spurious_cnt <= '0;
      end else begin
         if (done_seen && stat_done_cnt != '1) stat_done_cnt <= stat_done_cnt + 1'b1;
         if (timed_out && stat_timeout_cnt != '1) stat_timeout_cnt <= stat_timeout_cnt + 1'b1;
         if (spurious && stat_spurious_cnt != '1) stat_spurious_cnt <= stat_spurious_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Self-checking bench for alu_cmd_master: a behavioural ALU, an in-order
// expectation queue checked every cycle, and directed latency/value checks.
module tb_alu_cmd_master;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_A, alu_B;
   logic [2:0]  alu_op;
   logic        alu_start, alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid, rsp_ready, rsp_err, busy;
   logic [15:0] rsp_result;
`ifdef ALU_CMD_MASTER_STATS_EN
   logic [15:0] stat_done_cnt, stat_timeout_cnt;
   logic [7:0]  stat_spurious_cnt;
`endif

   alu_cmd_master dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_A      (alu_A),
      .alu_B      (alu_B),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_result (alu_result),
      .alu_done   (alu_done),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy)
`ifdef ALU_CMD_MASTER_STATS_EN
      ,
      .stat_done_cnt     (stat_done_cnt),
      .stat_timeout_cnt  (stat_timeout_cnt),
      .stat_spurious_cnt (stat_spurious_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endfunction

   // What the ALU computes; the bench ALU and the expectations both use it
   function automatic logic [15:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return 16'(a) + 16'(b);
         3'd1:    return 16'(a) - 16'(b);
         3'd2:    return 16'(a) * 16'(b);
         3'd7:    return 16'hBEEF;
         default: return {a, b};
      endcase
   endfunction

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t iss_q[$];
   exp_t rsp_q[$];

   // ALU behaviour: done comes alu_lat cycles after start; 0 means never
   int alu_lat  = 3;
   bit spur_req = 1'b0;
   int m_cnt    = 0;
   bit m_pend   = 1'b0;
   logic [7:0] m_a, m_b;
   logic [2:0] m_op;

   initial begin
      alu_done   = 1'b0;
      alu_result = 16'h0;
      forever begin
         @(negedge clk);
         alu_done = 1'b0;
         if (spur_req) begin
            alu_done   = 1'b1;
            alu_result = 16'h5555;
            spur_req   = 1'b0;
         end
         if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_pend     = 1'b0;
               alu_done   = 1'b1;
               alu_result = ref_fn(m_a, m_b, m_op);
            end
         end
         if (alu_start && alu_lat > 0) begin
            m_pend = 1'b1;
            m_cnt  = alu_lat;
            m_a    = alu_A;
            m_b    = alu_B;
            m_op   = alu_op;
         end
      end
   end

   int unsigned push_cyc, start_cyc, done_cyc, rsp_rise_cyc;
   int unsigned n_start = 0, n_rsp_valid = 0, n_accept = 0;
   logic [15:0] last_res;
   logic        last_err;
   logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_err;
   logic [15:0] prev_res;

   // Per-cycle compare against the in-order model
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            iss_q.delete();
            rsp_q.delete();
            prev_stall = 1'b0;
            prev_valid = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("rsp_hold_valid", rsp_valid, 1);
               chk("rsp_hold_result", rsp_result, prev_res);
               chk("rsp_hold_err", rsp_err, prev_err);
            end
            if (alu_done) done_cyc = cyc;
            if (rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (rsp_valid) n_rsp_valid++;
            if (alu_start) begin
               n_start++;
               start_cyc = cyc;
               if (iss_q.size() == 0) begin
                  fail("start_without_command");
               end else begin
                  e = iss_q.pop_front();
                  chk("issue_a", alu_A, e.a);
                  chk("issue_b", alu_B, e.b);
                  chk("issue_op", alu_op, e.op);
               end
            end
            if (rsp_valid && rsp_ready) begin
               n_accept++;
               last_res = rsp_result;
               last_err = rsp_err;
               if (rsp_q.size() == 0) begin
                  fail("response_without_command");
               end else begin
                  e = rsp_q.pop_front();
                  chk("rsp_result", rsp_result, e.res);
                  chk("rsp_err", rsp_err, e.err);
                  chk("held_a", alu_A, e.a);
                  chk("held_b", alu_B, e.b);
                  chk("held_op", alu_op, e.op);
               end
            end
            if (cmd_valid && cmd_ready) begin
               e.a   = cmd_a;
               e.b   = cmd_b;
               e.op  = cmd_op;
               e.err = (alu_lat == 0) || (alu_lat > TIMEOUT);
               e.res = e.err ? 16'h0 : ref_fn(cmd_a, cmd_b, cmd_op);
               iss_q.push_back(e);
               rsp_q.push_back(e);
               push_cyc = cyc;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            prev_res   = rsp_result;
            prev_err   = rsp_err;
         end
      end
   end

   // Called just after a falling edge; returns at the falling edge after acceptance
   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bit ok = 1'b0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      for (int i = 0; i < 1000 && !ok; i++) begin
         #2;
         ok = cmd_ready;
         @(negedge clk);
      end
      if (!ok) fail("push_timeout");
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         #2;
         if (rsp_q.size() == 0 && !busy && !rsp_valid) ok = 1'b1;
      end
      if (!ok) fail(name);
      @(negedge clk);
   endtask

   logic [7:0] bp_a [5] = '{8'h10, 8'h22, 8'h05, 8'hF0, 8'h7F};
   logic [7:0] bp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h80};
   logic [2:0] bp_op[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};

   initial begin
      int unsigned c0, s0, v0, a0, rst_cyc;
`ifdef ALU_CMD_MASTER_STATS_EN
      logic [15:0] sd0;
      logic [7:0]  ss0;
`endif
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = 8'h0;
      cmd_b     = 8'h0;
      cmd_op    = 3'h0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_alu_start", alu_start, 0);
      chk("reset_busy", busy, 0);
      chk("reset_alu_A", alu_A, 0);
      chk("reset_rsp_result", rsp_result, 0);
      chk("reset_rsp_err", rsp_err, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single operation
      alu_lat = 3;
      s0 = n_start;
      push(8'h0F, 8'h01, 3'd0);
      cmd_valid = 1'b0;
      wait_idle(50, "single_idle_timeout");
      chk("single_start_lat", start_cyc - push_cyc, 2);
      chk("single_done_lat", done_cyc - start_cyc, 3);
      chk("single_rsp_lat", rsp_rise_cyc - done_cyc, 1);
      chk("single_start_count", n_start - s0, 1);
      chk("single_result", last_res, 16'h0010);
      chk("single_err", last_err, 0);

      // Fill and backpressure
      rsp_ready = 1'b0;
      a0 = n_accept;
      c0 = cyc;
      for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], bp_op[i]);
      cmd_valid = 1'b0;
      chk("bp_push_cycles", cyc - c0, 5);
      #2;
      chk("bp_ready_low_when_full", cmd_ready, 0);
      chk("bp_busy", busy, 1);
      @(negedge clk);
      repeat (10) @(negedge clk);
      rsp_ready = 1'b1;
      wait_idle(200, "bp_idle_timeout");
      chk("bp_accept_count", n_accept - a0, 5);
      chk("bp_last_result", last_res, 16'h00FF);

      // Timeout followed by a normal command
      alu_lat = 0;
      push(8'h12, 8'h34, 3'd0);
      cmd_valid = 1'b0;
      wait_idle(400, "timeout_idle_timeout");
      chk("timeout_rsp_lat", rsp_rise_cyc - start_cyc, 256);
      chk("timeout_result", last_res, 16'h0000);
      chk("timeout_err", last_err, 1);
`ifdef ALU_CMD_MASTER_STATS_EN
      chk("stat_timeout_one", stat_timeout_cnt, 1);
`endif
      alu_lat = 3;
      push(8'h20, 8'h05, 3'd1);
      cmd_valid = 1'b0;
      wait_idle(50, "post_timeout_idle_timeout");
      chk("post_timeout_result", last_res, 16'h001B);
      chk("post_timeout_err", last_err, 0);

      // Done arrives on the same cycle the timeout would fire
      alu_lat = TIMEOUT;
      push(8'h01, 8'h02, 3'd7);
      cmd_valid = 1'b0;
      wait_idle(400, "race_idle_timeout");
      chk("race_rsp_lat", rsp_rise_cyc - start_cyc, 256);
      chk("race_result", last_res, 16'hBEEF);
      chk("race_err", last_err, 0);
`ifdef ALU_CMD_MASTER_STATS_EN
      chk("stat_done_before_reset", stat_done_cnt, 8);
`endif

      // Reset while waiting with two commands still queued
      alu_lat = 30;
      push(8'h01, 8'h01, 3'd0);
      push(8'h02, 8'h02, 3'd0);
      push(8'h03, 8'h03, 3'd0);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      chk("midop_busy", busy, 1);
      chk("midop_full_ready", cmd_ready, 1);
      @(negedge clk);
      reset   = 1'b1;
      rst_cyc = cyc;
      @(negedge clk);
      reset = 1'b0;
      s0 = n_start;
      v0 = n_rsp_valid;
      repeat (40) @(negedge clk);
      #2;
      chk("midop_late_done_seen", done_cyc > rst_cyc, 1);
      chk("midop_no_rsp", n_rsp_valid - v0, 0);
      chk("midop_no_start", n_start - s0, 0);
      chk("midop_cmd_ready", cmd_ready, 1);
      chk("midop_busy_clear", busy, 0);
`ifdef ALU_CMD_MASTER_STATS_EN
      chk("stat_done_after_reset", stat_done_cnt, 0);
      chk("stat_spur_after_reset", stat_spurious_cnt, 1);
      sd0 = stat_done_cnt;
      ss0 = stat_spurious_cnt;
`endif
      @(negedge clk);

      // Spurious done while idle
      v0 = n_rsp_valid;
      spur_req = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      chk("spur_no_rsp", n_rsp_valid - v0, 0);
      chk("spur_busy", busy, 0);
`ifdef ALU_CMD_MASTER_STATS_EN
      chk("spur_stat_spurious", stat_spurious_cnt, ss0 + 8'd1);
      chk("spur_stat_done", stat_done_cnt, sd0);
`endif
      @(negedge clk);

      // Fastest ALU after all of the above
      alu_lat = 1;
      push(8'hFF, 8'hFF, 3'd2);
      cmd_valid = 1'b0;
      wait_idle(50, "final_idle_timeout");
      chk("final_result", last_res, 16'hFE01);
      chk("final_rsp_lat", rsp_rise_cyc - start_cyc, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_watchdog (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Initiator for the ALU start/done handshake. Accepts operand/opcode commands on a valid/ready input and buffers them in a small FIFO.
- Issues each command to the ALU, waits for done, captures result, and returns it on a valid/ready response port.
- Sits between a host/sequencer and the alu block, replacing the bench driver in synthesizable system builds.

Parameters:
- DATA_W, 8, width of operands A and B
- OP_W, 3, width of opcode (passed through opaquely)
- RES_W, 16, width of ALU result
- QDEPTH, 4, command FIFO depth (power of 2, >=2)
- TIMEOUT, 255, max cycles to wait for done after start before aborting

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_op  in  OP_W  opcode
- alu_A  out  DATA_W  to ALU A
- alu_B  out  DATA_W  to ALU B
- alu_op  out  OP_W  to ALU op
- alu_start  out  1  one-cycle start pulse
- alu_result  in  RES_W  from ALU result
- alu_done  in  1  from ALU done
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  RES_W  captured result (0 on timeout)
- rsp_err  out  1  1 = timeout abort
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (sync, active-high): FIFO emptied, FSM to IDLE, all outputs 0 except cmd_ready=1. A reset mid-operation abandons the in-flight command. No response is produced for it, and a late alu_done is ignored.
- FIFO: a push happens when cmd_valid & cmd_ready. cmd_ready = !full, registered from count, with no same-cycle pop bypass. Pointers are log2(QDEPTH) bits and wrap; count is log2(QDEPTH)+1 bits. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop the head into the alu_A/alu_B/alu_op registers and go to ISSUE the next cycle.
- ISSUE: alu_start=1 for exactly this cycle; timeout counter cleared; go to WAIT.
- WAIT: alu_done is sampled starting the cycle after the start pulse.
  - On alu_done=1: capture alu_result into rsp_result, rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT without done: rsp_result=0, rsp_err=1, go to RESP.
  - If done arrives in the same cycle as the counter reaching TIMEOUT, done wins (err=0).
- RESP: rsp_valid=1; rsp_result and rsp_err are held stable until rsp_valid & rsp_ready. On acceptance go to IDLE, and the next command issues no earlier than the following cycle.
- Latency: an accepted command into an empty FIFO with the FSM idle gives start 2 cycles after the push; rsp_valid follows 1 cycle after done.
- alu_A/alu_B/alu_op are held stable from ISSUE until leaving RESP.
- alu_done seen in IDLE, ISSUE or RESP is ignored (spurious).
- One command is outstanding at the ALU at a time; responses are returned in command order.

Optional Feature:
- Macro ALU_CMD_MASTER_STATS_EN.
- When defined, adds outputs stat_done_cnt (16), stat_timeout_cnt (16) and stat_spurious_cnt (8). These count completed ops, timeouts, and ignored alu_done pulses respectively; they saturate at max value and are cleared by reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_cmd_pkg holds:
  - state enum typedef (IDLE/ISSUE/WAIT/RESP);
  - packed cmd_t struct {a, b, op};
  - default width constants.
- One sub-module: alu_cmd_fifo (parameterized synchronous FIFO of cmd_t with push/pop/full/empty/count). The FSM, timeout counter and response register stay in the top.

Test Plan:
- Single op: push a=8'h0F, b=8'h01, op=3'd0; ALU model raises done 3 cycles after start with result 16'h0010 -> alu_start high once, 2 cycles after push; rsp_valid 1 cycle after done; rsp_result=16'h0010; rsp_err=0.
- Fill/backpressure: push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after the 4th buffered entry (1 in flight plus 4 queued, full). All 5 responses later return in push order with the correct results.
- Timeout: ALU model never asserts done, TIMEOUT=255 -> rsp_valid exactly 256 cycles after the start pulse, rsp_result=16'h0000, rsp_err=1. A following command proceeds normally.
- Done/timeout race: done asserted on the cycle the counter hits TIMEOUT with result 16'hBEEF -> rsp_result=16'hBEEF, rsp_err=0.
- Reset mid-op: assert reset in WAIT with 2 commands queued, then deassert; the ALU then raises done -> no rsp_valid, cmd_ready=1, busy=0, alu_start stays 0.
- Spurious done: pulse alu_done while IDLE -> no response; with ALU_CMD_MASTER_STATS_EN, stat_spurious_cnt=1 and stat_done_cnt unchanged.
